// File: rtl/mc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mc_sequencer
// Purpose  : Single-clock multi-cycle sequencer for the SPIM datapath. Each
//            instruction is stepped through FETCH, DECODE, EXEC, MEM and WB.
//            The sequencer drives the datapath enables, mux selects and aluop.
//            It issues handshaked instruction/data memory requests, and those
//            memories may insert wait states.
// Build    : define MC_SEQ_PERF_EN to include the 32-bit retired-instruction
//            counter. When it is undefined, retired_cnt is tied to zero.
// Ports    : clk, reset (sync, active-high), run, opcode[5:0], zero, mem_ready
//            -> imem_req, dmem_req, dmem_we, pc_we, pc_sel, ir_we, reg_we,
//               regdst, memtoreg, alusrc, aluop[1:0], state[2:0], halted,
//               err_illegal, err_timeout, retired_cnt[31:0]
// Revision : 1.0 - initial release
// ============================================================================
module mc_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        ir_we,
  output logic        reg_we,
  output logic        regdst,
  output logic        memtoreg,
  output logic        alusrc,
  output logic [1:0]  aluop,
  output logic [2:0]  state,
  output logic        halted,
  output logic        err_illegal,
  output logic        err_timeout,
  output logic [31:0] retired_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd7;

  localparam logic [1:0] C_R   = 2'd0;
  localparam logic [1:0] C_LW  = 2'd1;
  localparam logic [1:0] C_SW  = 2'd2;
  localparam logic [1:0] C_BEQ = 2'd3;

  localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(TIMEOUT);

  logic [2:0]      state_q, state_d;
  logic [1:0]      cls_q, cls_d;
  logic [TO_W-1:0] wait_q, wait_d;
  logic            err_illegal_q, err_illegal_d;
  logic            err_timeout_q, err_timeout_d;

  logic [TO_W-1:0] wait_inc;
  logic [2:0]      boundary_state;

  assign wait_inc       = wait_q + TO_W'(1);
  // At an instruction boundary, run decides whether to continue or park.
  assign boundary_state = run ? S_FETCH : S_IDLE;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cls_q         <= C_R;
      wait_q        <= '0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cls_q         <= cls_d;
      wait_q        <= wait_d;
      err_illegal_q <= err_illegal_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cls_d         = cls_q;
    // The wait counter is zero whenever it is not counting. This makes it
    // start from zero on every entry into FETCH or MEM.
    wait_d        = '0;
    err_illegal_d = err_illegal_q;
    err_timeout_d = err_timeout_q;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end

      S_FETCH: begin
        // Check mem_ready first, so a completion on the last allowed wait
        // cycle still succeeds.
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (wait_inc == TIMEOUT_C) begin
          err_timeout_d = 1'b1;
          state_d       = S_ERR;
        end else begin
          wait_d = wait_inc;
        end
      end

      S_DECODE: begin
        case (opcode)
          6'b000000: begin cls_d = C_R;   state_d = S_EXEC; end
          6'b100011: begin cls_d = C_LW;  state_d = S_EXEC; end
          6'b101011: begin cls_d = C_SW;  state_d = S_EXEC; end
          6'b000100: begin cls_d = C_BEQ; state_d = S_EXEC; end
          default: begin
            err_illegal_d = 1'b1;
            state_d       = S_ERR;
          end
        endcase
      end

      S_EXEC: begin
        case (cls_q)
          C_R:     state_d = S_WB;
          C_LW,
          C_SW:    state_d = S_MEM;
          default: state_d = boundary_state;  // BEQ retires in EXEC
        endcase
      end

      S_MEM: begin
        if (mem_ready) begin
          state_d = (cls_q == C_SW) ? boundary_state : S_WB;
        end else if (wait_inc == TIMEOUT_C) begin
          err_timeout_d = 1'b1;
          state_d       = S_ERR;
        end else begin
          wait_d = wait_inc;
        end
      end

      S_WB: begin
        state_d = boundary_state;
      end

      S_ERR: begin
        state_d = S_ERR;
      end

      default: begin
        // Encoding 6 is unreachable. Recover through IDLE.
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    ir_we    = 1'b0;
    reg_we   = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrc   = 1'b0;
    aluop    = 2'b00;
    halted   = 1'b0;

    case (state_q)
      S_IDLE: begin
        halted = 1'b1;
      end

      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = mem_ready;
        pc_we    = mem_ready;  // pc_sel stays 0: pc+4
      end

      S_EXEC: begin
        case (cls_q)
          C_R: begin
            aluop = 2'b10;
          end
          C_LW,
          C_SW: begin
            aluop  = 2'b00;
            alusrc = 1'b1;
          end
          default: begin
            aluop  = 2'b01;
            pc_sel = 1'b1;
            pc_we  = zero;
          end
        endcase
      end

      S_MEM: begin
        // Address operands stay stable for the whole wait.
        dmem_req = 1'b1;
        dmem_we  = (cls_q == C_SW);
        aluop    = 2'b00;
        alusrc   = 1'b1;
      end

      S_WB: begin
        reg_we   = 1'b1;
        regdst   = (cls_q == C_R);
        memtoreg = (cls_q == C_LW);
      end

      default: ;
    endcase
  end

  assign state       = state_q;
  assign err_illegal = err_illegal_q;
  assign err_timeout = err_timeout_q;

  // --------------------------------------------------------------------------
  // Optional retired-instruction counter
  // --------------------------------------------------------------------------
`ifdef MC_SEQ_PERF_EN
  logic        retire;
  logic [31:0] retired_cnt_q, retired_cnt_d;

  always_comb begin
    retire = ((state_q == S_EXEC) && (cls_q == C_BEQ))
          || ((state_q == S_MEM)  && (cls_q == C_SW) && mem_ready)
          ||  (state_q == S_WB);
    retired_cnt_d = retired_cnt_q + (retire ? 32'd1 : 32'd0);  // wraps naturally
  end

  always_ff @(posedge clk) begin
    if (reset) retired_cnt_q <= '0;
    else       retired_cnt_q <= retired_cnt_d;
  end

  assign retired_cnt = retired_cnt_q;
`else
  assign retired_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mc_sequencer
// Purpose  : Scoreboard bench for mc_sequencer. Each directed cycle pushes its
//            hand-derived expected output bundle. A negedge monitor pops each
//            entry and compares it against the DUT outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_sequencer;

  typedef struct packed {
    logic       imem;
    logic       dmem;
    logic       dwe;
    logic       pcwe;
    logic       pcsel;
    logic       irwe;
    logic       regwe;
    logic       regdst;
    logic       m2r;
    logic       alusrc;
    logic [1:0] aluop;
    logic [2:0] st;
    logic       halted;
    logic       eill;
    logic       eto;
  } outs_t;

`ifdef MC_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BAD = 6'b111111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        imem_req, dmem_req, dmem_we, pc_we, pc_sel, ir_we;
  logic        reg_we, regdst, memtoreg, alusrc, halted;
  logic        err_illegal, err_timeout;
  logic [1:0]  aluop;
  logic [2:0]  state;
  logic [31:0] retired_cnt;

  mc_sequencer #(.TIMEOUT(16), .TO_W(5)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .imem_req(imem_req), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .pc_we(pc_we), .pc_sel(pc_sel), .ir_we(ir_we),
    .reg_we(reg_we), .regdst(regdst), .memtoreg(memtoreg), .alusrc(alusrc),
    .aluop(aluop), .state(state), .halted(halted),
    .err_illegal(err_illegal), .err_timeout(err_timeout),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard
  outs_t       exp_q[$];
  logic [31:0] ret_q[$];
  string       nm_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_ret = 32'd0;

  outs_t       m_e, m_act;
  logic [31:0] m_r;
  string       m_s;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      m_e   = exp_q.pop_front();
      m_r   = ret_q.pop_front();
      m_s   = nm_q.pop_front();
      m_act = {imem_req, dmem_req, dmem_we, pc_we, pc_sel, ir_we, reg_we,
               regdst, memtoreg, alusrc, aluop, state, halted,
               err_illegal, err_timeout};
      n_vec++;
      if (m_act !== m_e || retired_cnt !== m_r) begin
        n_bad++;
        $display("FAIL %s: got outs=%05h ret=%0d, want outs=%05h ret=%0d",
                 m_s, m_act, retired_cnt, m_e, m_r);
      end
    end
  end

  // Expected-output templates
  function automatic outs_t o_idle();
    outs_t o = '0; o.halted = 1'b1; return o;
  endfunction
  function automatic outs_t o_fetch(input bit rdy);
    outs_t o = '0; o.st = 3'd1; o.imem = 1'b1; o.irwe = rdy; o.pcwe = rdy; return o;
  endfunction
  function automatic outs_t o_dec();
    outs_t o = '0; o.st = 3'd2; return o;
  endfunction
  function automatic outs_t o_exec_r();
    outs_t o = '0; o.st = 3'd3; o.aluop = 2'b10; return o;
  endfunction
  function automatic outs_t o_exec_ls();
    outs_t o = '0; o.st = 3'd3; o.alusrc = 1'b1; return o;
  endfunction
  function automatic outs_t o_exec_beq(input bit z);
    outs_t o = '0; o.st = 3'd3; o.aluop = 2'b01; o.pcsel = 1'b1; o.pcwe = z; return o;
  endfunction
  function automatic outs_t o_mem(input bit sw);
    outs_t o = '0; o.st = 3'd4; o.dmem = 1'b1; o.dwe = sw; o.alusrc = 1'b1; return o;
  endfunction
  function automatic outs_t o_wb(input bit rd, input bit m2r);
    outs_t o = '0; o.st = 3'd5; o.regwe = 1'b1; o.regdst = rd; o.m2r = m2r; return o;
  endfunction
  function automatic outs_t o_err(input bit ill, input bit to);
    outs_t o = '0; o.st = 3'd7; o.eill = ill; o.eto = to; return o;
  endfunction

  // One clock cycle: drive inputs, queue the expected outputs, advance.
  task automatic cyc(input bit rst, input bit rn, input logic [5:0] op,
                     input bit z, input bit rdy, input outs_t e,
                     input bit ret, input string nm);
    reset = rst; run = rn; opcode = op; zero = z; mem_ready = rdy;
    exp_q.push_back(e);
    ret_q.push_back(exp_ret);
    nm_q.push_back(nm);
    @(posedge clk); #1;
    if (rst)             exp_ret = 32'd0;
    else if (ret && PERF) exp_ret = exp_ret + 32'd1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset for 3 cycles with run low
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cyc(0, 0, OP_R, 0, 0, o_idle(), 0, "reset_idle0");
    cyc(0, 0, OP_R, 0, 1, o_idle(), 0, "reset_idle1");
    cyc(0, 1, OP_R, 0, 0, o_idle(), 0, "idle_run_raised");

    // R-type, zero wait; run dropped mid-instruction must not abort it
    cyc(0, 1, OP_R, 0, 1, o_fetch(1), 0, "r_fetch");
    cyc(0, 0, OP_R, 0, 1, o_dec(),    0, "r_decode");
    cyc(0, 1, OP_R, 0, 0, o_exec_r(), 0, "r_exec");
    cyc(0, 1, OP_R, 0, 0, o_wb(1, 0), 1, "r_wb");

    // LW with 3 wait cycles in both FETCH and MEM (11 cycles)
    for (int i = 0; i < 3; i++) cyc(0, 1, OP_LW, 0, 0, o_fetch(0), 0, "lw_fetch_wait");
    cyc(0, 1, OP_LW, 0, 1, o_fetch(1), 0, "lw_fetch_done");
    cyc(0, 1, OP_LW, 0, 0, o_dec(),     0, "lw_decode");
    cyc(0, 1, OP_LW, 0, 0, o_exec_ls(), 0, "lw_exec");
    for (int i = 0; i < 3; i++) cyc(0, 1, OP_LW, 0, 0, o_mem(0), 0, "lw_mem_wait");
    cyc(0, 1, OP_LW, 0, 1, o_mem(0),   0, "lw_mem_done");
    cyc(0, 1, OP_LW, 0, 0, o_wb(0, 1), 1, "lw_wb");

    // BEQ taken, then BEQ not taken and parked at the boundary
    cyc(0, 1, OP_BEQ, 1, 1, o_fetch(1),    0, "beq1_fetch");
    cyc(0, 1, OP_BEQ, 1, 0, o_dec(),       0, "beq1_decode");
    cyc(0, 1, OP_BEQ, 1, 0, o_exec_beq(1), 1, "beq1_exec_taken");
    cyc(0, 1, OP_BEQ, 0, 1, o_fetch(1),    0, "beq0_fetch");
    cyc(0, 1, OP_BEQ, 0, 0, o_dec(),       0, "beq0_decode");
    cyc(0, 0, OP_BEQ, 0, 0, o_exec_beq(0), 1, "beq0_exec_not_taken");
    cyc(0, 1, OP_BEQ, 0, 0, o_idle(),      0, "beq0_parked_idle");

    // SW whose mem_ready lands on the 16th wait cycle: no error
    cyc(0, 1, OP_SW, 0, 1, o_fetch(1),  0, "sw_fetch");
    cyc(0, 1, OP_SW, 0, 0, o_dec(),     0, "sw_decode");
    cyc(0, 1, OP_SW, 0, 0, o_exec_ls(), 0, "sw_exec");
    for (int i = 0; i < 15; i++) cyc(0, 1, OP_SW, 0, 0, o_mem(1), 0, "sw_mem_wait");
    cyc(0, 1, OP_SW, 0, 1, o_mem(1), 1, "sw_mem_ready_at_limit");

    // SW whose mem_ready never arrives: timeout after 16 request cycles
    cyc(0, 1, OP_SW, 0, 1, o_fetch(1),  0, "swto_fetch");
    cyc(0, 1, OP_SW, 0, 0, o_dec(),     0, "swto_decode");
    cyc(0, 1, OP_SW, 0, 0, o_exec_ls(), 0, "swto_exec");
    for (int i = 0; i < 16; i++) cyc(0, 1, OP_SW, 0, 0, o_mem(1), 0, "swto_mem_wait");
    cyc(0, 1, OP_SW, 0, 1, o_err(0, 1), 0, "swto_err");
    cyc(0, 1, OP_SW, 0, 1, o_err(0, 1), 0, "swto_err_hold");

    // Reset leaves ERR; illegal opcode then faults
    cyc(1, 0, OP_R,   0, 0, o_err(0, 1), 0, "rst_from_err");
    cyc(0, 1, OP_BAD, 0, 0, o_idle(),    0, "after_rst_idle");
    cyc(0, 1, OP_BAD, 0, 1, o_fetch(1),  0, "bad_fetch");
    cyc(0, 1, OP_BAD, 0, 0, o_dec(),     0, "bad_decode");
    cyc(0, 0, OP_R,   0, 1, o_err(1, 0), 0, "bad_err");
    cyc(0, 1, OP_R,   0, 1, o_err(1, 0), 0, "bad_err_sticky");

    // Reset asserted mid-MEM drops the data request
    cyc(1, 0, OP_R,  0, 0, o_err(1, 0), 0, "rst_from_illegal");
    cyc(0, 1, OP_SW, 0, 0, o_idle(),    0, "rst2_idle");
    cyc(0, 1, OP_SW, 0, 1, o_fetch(1),  0, "rst2_fetch");
    cyc(0, 1, OP_SW, 0, 0, o_dec(),     0, "rst2_decode");
    cyc(0, 1, OP_SW, 0, 0, o_exec_ls(), 0, "rst2_exec");
    cyc(0, 1, OP_SW, 0, 0, o_mem(1),    0, "rst2_mem_wait");
    cyc(1, 0, OP_SW, 0, 0, o_mem(1),    0, "rst2_mem_during_reset");
    cyc(0, 0, OP_SW, 0, 1, o_idle(),    0, "rst2_idle_after_mem");
    cyc(0, 0, OP_SW, 0, 0, o_idle(),    0, "rst2_idle_hold");

    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d vectors left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
Multi-cycle sequencer for the SPIM datapath. It replaces the fixed pclk/iclk/dclk phasing with a single-clock FSM. Per instruction it steps through FETCH, DECODE, EXEC, MEM and WB, and drives write enables, mux selects and aluop to the datapath. It also issues handshaked requests to instruction and data memories, which may insert wait states.

Parameters:
- TIMEOUT, 16, max consecutive cycles a memory request may wait without mem_ready before the FSM faults.
- TO_W, 5, width of the wait counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  1 = execute; sampled in IDLE and at instruction boundaries.
- opcode  in  6  instruction[31:26] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completion strobe for the current imem_req/dmem_req.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data write (qualified by dmem_req).
- pc_we  out  1  PC load enable.
- pc_sel  out  1  0 = pc+4, 1 = branch target (add_result).
- ir_we  out  1  instruction register load.
- reg_we  out  1  register file write.
- regdst  out  1  1 = rd, 0 = rt.
- memtoreg  out  1  1 = memory data to register file.
- alusrc  out  1  1 = sign_extend operand.
- aluop  out  2  00 add, 01 sub, 10 funct-decoded.
- state  out  3  current state encoding.
- halted  out  1  1 in IDLE.
- err_illegal  out  1  sticky illegal-opcode flag.
- err_timeout  out  1  sticky memory-timeout flag.
- retired_cnt  out  32  retired instruction count (see Optional Feature).

Behaviour:
- Reset: clk and reset are the only clock and reset. Reset is synchronous and active-high. It forces state = IDLE and clears the wait counter, the class register, both error flags and retired_cnt. The next cycle, every output is 0 except halted = 1. An in-flight memory request is dropped (req low the next cycle).
- Outputs are combinational decodes of the state register plus the class register (cls_q). Anything not listed for a state is 0.
- State encoding: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, ERR = 7.
- IDLE:
  - halted = 1.
  - run = 1 -> FETCH.
- FETCH:
  - imem_req = 1.
  - On mem_ready: ir_we = 1, pc_we = 1, pc_sel = 0 -> DECODE.
- DECODE: latch cls_q from opcode.
  - 000000 = R-type; 100011 = LW; 101011 = SW; 000100 = BEQ -> EXEC.
  - Any other opcode: set err_illegal -> ERR.
- EXEC:
  - R: aluop = 10, alusrc = 0 -> WB.
  - LW/SW: aluop = 00, alusrc = 1 -> MEM.
  - BEQ: aluop = 01, pc_sel = 1, pc_we = zero. Instruction retires here; go to boundary.
- MEM:
  - dmem_req = 1, dmem_we = (cls_q == SW), aluop = 00, alusrc = 1 held for the whole wait.
  - On mem_ready: SW retires (boundary); LW -> WB.
- WB:
  - reg_we = 1; regdst = 1 for R; memtoreg = 1 for LW.
  - Instruction retires here; go to boundary.
- Boundary: run = 1 -> FETCH; run = 0 -> IDLE. run going low mid-instruction never aborts the instruction.
- Wait counter:
  - Cleared on entry to FETCH/MEM.
  - Increments each cycle in FETCH/MEM with mem_ready = 0.
  - When it reaches TIMEOUT with mem_ready still 0: set err_timeout -> ERR.
  - If mem_ready arrives in the same cycle the count reaches TIMEOUT, mem_ready wins.
- mem_ready outside FETCH/MEM is ignored.
- ERR: all enables 0; error flags hold. Left only by reset.
- Cycle counts with zero-wait memory: R = 4, LW = 5, SW = 4, BEQ = 3 cycles.

Optional Feature:
- MC_SEQ_PERF_EN defined: retired_cnt is a 32-bit counter.
  - +1 on each retirement (BEQ in EXEC, SW on MEM completion, R/LW in WB).
  - Wraps 0xFFFFFFFF -> 0.
  - Cleared by reset.
- Undefined: retired_cnt tied to 0 and no counter logic is present.

Test Plan:
- Reset held 3 cycles, run = 0 -> state = 0, halted = 1, all enables 0. Raise run -> imem_req = 1 the following cycle.
- Zero-wait R-type (opcode 000000) -> FETCH, DECODE, EXEC (aluop = 10), WB (reg_we = 1, regdst = 1) over 4 cycles; retired_cnt = 1.
- LW with mem_ready delayed 3 cycles in both FETCH and MEM -> imem_req held 4 cycles, then dmem_req held 4 cycles with dmem_we = 0, then WB with memtoreg = 1; 11 cycles total.
- BEQ with zero = 1 -> pc_we = 1, pc_sel = 1 in EXEC. Repeat with zero = 0 -> pc_we = 0. Both return to FETCH after 3 cycles.
- SW with mem_ready never asserted, TIMEOUT = 16 -> dmem_req = 1, dmem_we = 1 for 16 cycles, then err_timeout = 1, state = 7. mem_ready exactly on the 16th wait cycle -> no error.
- Opcode 111111 -> err_illegal = 1, state = 7, sticky. Reset asserted mid-MEM on another run -> IDLE and flags cleared the next cycle.
